fifo_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter that shares one FIFO write port among NUM_REQ producers.
- Grants one requester at a time and drives wr_en/data_in into the FIFO.
- Checks the FIFO's wr_ack/overflow response, retries on overflow up to MAX_RETRY, then drops the word.
- Sits between the producer blocks and the FIFO write side; keeps saturating write/drop statistics.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/shared_pkg.sv | 4 +
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fifo_arb_pkg.sv
// Types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;
    localparam int MAX_REQ = 8;

    typedef logic [2:0] req_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } arb_state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input req_idx_t idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/shared_pkg.sv
// Parameters shared by every block on the FIFO write path.
package shared_pkg;
    localparam int FIFO_WIDTH = 16;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request/grant bus plus the FIFO write-side handshake.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            drop;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;

    modport master (
        input  req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        output gnt, done, drop, fifo_wr_en, fifo_data_in
    );

    modport slave (
        output req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        input  gnt, done, drop, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set req at or after ptr_i, wrapping modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  req_idx_t           ptr_i,
    output logic               valid_o,
    output req_idx_t           idx_o
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    // rot[k] is the request sitting k slots after the pointer
    assign dbl = {req_i, req_i};
    assign rot = NUM_REQ'(dbl >> ptr_i);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid_o = 1'b1;
                idx_o   = req_idx_t'((int'(ptr_i) + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of one FIFO write port: req in IDLE -> fifo_wr_en next cycle -> done/drop the cycle after.
// No grant while fifo_full; an overflowed owner waits in HOLD for space and is dropped after MAX_RETRY attempts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
    parameter int MAX_RETRY  = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_wr_arbiter_if.master    bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] wr_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    localparam int                   RETRY_W  = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0]   LAST_TRY = RETRY_W'(MAX_RETRY - 1);
    localparam req_idx_t             LAST_IDX = req_idx_t'(NUM_REQ - 1);

    arb_state_e            state_q, state_d;
    req_idx_t              owner_q, owner_d;
    req_idx_t              rr_ptr_q, rr_ptr_d;
    req_idx_t              pick_idx, next_ptr;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                  pick_vld, nak, done_hit, drop_hit;
    logic [NUM_REQ-1:0]    owner_oh;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    assign owner_oh = NUM_REQ'(onehot(owner_q));
    assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    // A missing response is handled exactly like an overflow
    assign nak      = bus.fifo_overflow | ~bus.fifo_wr_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            data_q     <= '0;
            retry_q    <= '0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            data_q     <= data_d;
            retry_q    <= retry_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        data_d     = data_q;
        retry_d    = retry_q;
        wr_cnt_d   = wr_cnt_q;
        drop_cnt_d = drop_cnt_q;
        done_hit   = 1'b0;
        drop_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld && !bus.fifo_full) begin
                    owner_d = pick_idx;
                    data_d  = bus.req_data[int'(pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
                    retry_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.fifo_wr_ack) begin
                    done_hit = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                    if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
                end else if (nak && retry_q == LAST_TRY) begin
                    drop_hit = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
                end else begin
                    // Pointer stays put so the owner keeps the port through its retries
                    retry_d = retry_q + 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!bus.fifo_full) state_d = ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy             = (state_q != IDLE);
    assign bus.gnt          = busy ? owner_oh : '0;
    assign bus.done         = done_hit ? owner_oh : '0;
    assign bus.drop         = drop_hit ? owner_oh : '0;
    assign bus.fifo_wr_en   = (state_q == ISSUE);
    assign bus.fifo_data_in = data_q;
    assign wr_cnt           = wr_cnt_q;
    assign drop_cnt         = drop_cnt_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: scoreboard queues filled by stimulus, drained by a negedge monitor.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int FW      = 16;
    localparam int CW      = 8;

    typedef struct packed {
        logic [NUM_REQ-1:0] gnt;
        logic [FW-1:0]      data;
    } wr_exp_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] done;
        logic [NUM_REQ-1:0] drop;
    } res_exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          busy;
    logic [CW-1:0] wr_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;
    int fifo_mode = 0;  // 0: ack, 1: overflow, 2: ack and overflow together
    int exp_wr = 0;
    int exp_drop = 0;
    logic [FW-1:0] words [NUM_REQ];

    wr_exp_t  wr_q [$];
    res_exp_t res_q [$];

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_WIDTH (FW),
        .MAX_RETRY  (3),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .wr_cnt   (wr_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // FIFO write side: response registered on the write edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fifo_wr_ack   <= 1'b0;
            bus.fifo_overflow <= 1'b0;
        end else begin
            bus.fifo_wr_ack   <= bus.fifo_wr_en && (fifo_mode != 1);
            bus.fifo_overflow <= bus.fifo_wr_en && (fifo_mode != 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_exp_t  we;
        res_exp_t re;
        if (rst_n) begin
            if (bus.fifo_wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {bus.gnt, bus.fifo_data_in}, '0);
                end else begin
                    we = wr_q.pop_front();
                    chk("write_gnt_data", {bus.gnt, bus.fifo_data_in}, we);
                end
            end
            if ((|bus.done) || (|bus.drop)) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", {bus.done, bus.drop}, '0);
                end else begin
                    re = res_q.pop_front();
                    chk("result_done_drop", {bus.done, bus.drop}, re);
                end
            end
        end
    end

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic push_wr(input int i);
        wr_q.push_back({oh(i), words[i]});
    endtask

    task automatic push_done(input int i);
        res_q.push_back({oh(i), {NUM_REQ{1'b0}}});
        if (exp_wr < 255) exp_wr++;
    endtask

    task automatic push_drop(input int i);
        res_q.push_back({{NUM_REQ{1'b0}}, oh(i)});
        if (exp_drop < 255) exp_drop++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wr(input int n, input int budget);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < budget) begin
            tick();
            cyc++;
            if (bus.fifo_wr_en) seen++;
        end
        chk("wait_wr_timeout", 64'(seen), 64'(n));
    endtask

    task automatic wait_res(input int budget);
        int cyc = 0;
        logic hit = 1'b0;
        while (!hit && cyc < budget) begin
            tick();
            cyc++;
            hit = (|bus.done) || (|bus.drop);
        end
        chk("wait_result_timeout", 64'(hit), 64'(1));
    endtask

    task automatic wait_idle(input int budget);
        int cyc = 0;
        do begin
            tick();
            cyc++;
        end while (busy && cyc < budget);
        chk("wait_idle_timeout", 64'(busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        words[0] = 16'h1234;
        words[1] = 16'h5A5A;
        words[2] = 16'hABCD;
        words[3] = 16'hC0DE;
        bus.req_data  = {words[3], words[2], words[1], words[0]};
        bus.req       = 4'b1111;
        bus.fifo_full = 1'b0;

        // reset with every requester active
        repeat (3) tick();
        chk("rst_gnt", 64'(bus.gnt), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_drop", 64'(bus.drop), 0);
        chk("rst_wr_en", 64'(bus.fifo_wr_en), 0);
        chk("rst_data_in", 64'(bus.fifo_data_in), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_wr_cnt", 64'(wr_cnt), 0);
        chk("rst_drop_cnt", 64'(drop_cnt), 0);
        push_wr(0); push_done(0);
        rst_n = 1'b1;
        wait_wr(1, 10);
        bus.req = '0;
        wait_idle(10);
        chk("first_wr_cnt", 64'(wr_cnt), 64'(exp_wr));

        // single write from requester 2, latency checked cycle by cycle
        push_wr(2); push_done(2);
        bus.req = 4'b0100;
        tick();
        chk("single_wr_en", 64'(bus.fifo_wr_en), 1);
        chk("single_data", 64'(bus.fifo_data_in), 64'(16'hABCD));
        chk("single_gnt", 64'(bus.gnt), 64'(4'b0100));
        tick();
        chk("single_done", 64'(bus.done), 64'(4'b0100));
        bus.req = '0;
        tick();
        chk("single_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
        chk("single_busy", 64'(busy), 0);

        // requester 3 moves the pointer back to 0
        push_wr(3); push_done(3);
        bus.req = 4'b1000;
        wait_res(10);
        bus.req = '0;
        wait_idle(10);

        // fairness: all requesting, then 1010 from pointer 2
        for (int k = 0; k < 6; k++) begin
            push_wr(k % 4); push_done(k % 4);
        end
        bus.req = 4'b1111;
        wait_wr(6, 40);
        push_wr(3); push_done(3);
        push_wr(1); push_done(1);
        bus.req = 4'b1010;
        wait_wr(2, 20);
        bus.req = '0;
        wait_idle(10);
        chk("fair_wr_cnt", 64'(wr_cnt), 64'(exp_wr));

        // backpressure: full FIFO blocks arbitration entirely
        bus.fifo_full = 1'b1;
        bus.req = 4'b0001;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.fifo_wr_en || busy) bad++;
        end
        chk("bp_no_activity", 64'(bad), 0);
        push_wr(0); push_done(0);
        bus.fifo_full = 1'b0;
        tick();
        chk("bp_release_wr_en", 64'(bus.fifo_wr_en), 1);
        wait_res(10);
        bus.req = '0;
        wait_idle(10);

        // overflow on every attempt: three writes then drop, HOLD stalls on full
        fifo_mode = 1;
        push_wr(1); push_wr(1); push_wr(1); push_drop(1);
        bus.req = 4'b0010;
        wait_wr(1, 10);
        bus.fifo_full = 1'b1;
        tick();
        tick();
        bus.req = 4'b0011;
        tick();
        tick();
        chk("hold_gnt", 64'(bus.gnt), 64'(4'b0010));
        chk("hold_busy", 64'(busy), 1);
        chk("hold_wr_en", 64'(bus.fifo_wr_en), 0);
        bus.fifo_full = 1'b0;
        wait_wr(2, 20);
        wait_res(10);
        bus.req = '0;
        wait_idle(10);
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("drop_wr_cnt_kept", 64'(wr_cnt), 64'(exp_wr));

        // pointer now 2
        fifo_mode = 0;
        push_wr(2); push_done(2);
        bus.req = 4'b1111;
        wait_wr(1, 10);
        bus.req = '0;
        wait_idle(10);

        // ack and overflow together: ack wins
        fifo_mode = 2;
        push_wr(0); push_done(0);
        bus.req = 4'b0001;
        wait_res(10);
        bus.req = '0;
        wait_idle(10);
        chk("both_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
        chk("both_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

        // reset during ISSUE (pointer is 1, so 0101 would pick 2)
        fifo_mode = 0;
        bus.req = 4'b0101;
        wait_wr(1, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 64'(bus.fifo_wr_en), 0);
        chk("midrst_gnt", 64'(bus.gnt), 0);
        chk("midrst_done", 64'(bus.done), 0);
        chk("midrst_busy", 64'(busy), 0);
        tick();
        tick();
        exp_wr = 0;
        exp_drop = 0;
        chk("midrst_wr_cnt", 64'(wr_cnt), 0);
        chk("midrst_drop_cnt", 64'(drop_cnt), 0);
        push_wr(0); push_done(0);
        rst_n = 1'b1;
        wait_res(10);
        bus.req = '0;
        wait_idle(10);
        chk("midrst_after_wr_cnt", 64'(wr_cnt), 64'(exp_wr));

        // counter saturation: 260 more accepted words from pointer 1
        for (int k = 0; k < 260; k++) begin
            push_wr((1 + k) % 4); push_done((1 + k) % 4);
        end
        bus.req = 4'b1111;
        wait_wr(260, 1000);
        bus.req = '0;
        wait_idle(10);
        chk("sat_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
        chk("sat_wr_cnt_max", 64'(wr_cnt), 64'(255));

        repeat (3) tick();
        chk("wr_queue_drained", 64'(wr_q.size()), 0);
        chk("res_queue_drained", 64'(res_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
